bcd_chain_counter: RTL and testbench

- Parametrised N-digit cascaded counter for the stopwatch datapath.
- Each digit counts modulo its own maximum; each digit's carry/borrow enables the next digit inside the block, so the top level no longer chains discrete per-digit counters.
- Adds up/down counting, synchronous clear, parallel load with clamping, a sticky overflow flag and an optional lap-capture register.
- Sits between the 100 Hz tick generator and the seven-segment display driver.

---
 rtl/bcd_chain_counter.sv | 123 ++++++++++++
 tb/tb_bcd_chain_counter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_chain_counter.sv
// Cascaded N-digit counter with per-digit modulus, up/down, clear, clamped load and sticky overflow.
// Define BCD_CHAIN_LAP_EN to build the lap-capture register; otherwise lap_q is tied to 0.
module bcd_chain_counter #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned DIGIT_W = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] MAX_VEC = 24'h595999
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          clr,
    input  logic                          up_dn,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
    input  logic                          lap,
    output logic [NUM_DIGITS*DIGIT_W-1:0] Q,
    output logic [NUM_DIGITS*DIGIT_W-1:0] lap_q,
    output logic [NUM_DIGITS-1:0]         digit_tc,
    output logic                          TC,
    output logic                          ovf
);

    localparam int unsigned W = NUM_DIGITS * DIGIT_W;

    logic [W-1:0]          count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [NUM_DIGITS-1:0] at_term;
    logic [NUM_DIGITS-1:0] tc_chain;
    logic [NUM_DIGITS-1:0] step;
    logic [W-1:0]          stepped;
    logic [W-1:0]          clamped;

    // Per-digit terminal detect, ripple enable chain, stepped and clamped values.
    always_comb begin
        at_term  = '0;
        tc_chain = '0;
        step     = '0;
        stepped  = '0;
        clamped  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (up_dn) begin
                at_term[i] = (count_q[i*DIGIT_W +: DIGIT_W] == MAX_VEC[i*DIGIT_W +: DIGIT_W]);
            end else begin
                at_term[i] = (count_q[i*DIGIT_W +: DIGIT_W] == '0);
            end
        end
        step[0]     = en;
        tc_chain[0] = en & at_term[0];
        for (int i = 1; i < NUM_DIGITS; i++) begin
            step[i]     = tc_chain[i-1];
            tc_chain[i] = tc_chain[i-1] & at_term[i];
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!step[i]) begin
                stepped[i*DIGIT_W +: DIGIT_W] = count_q[i*DIGIT_W +: DIGIT_W];
            end else if (at_term[i]) begin
                // Digit at its terminal wraps to the opposite end of its range.
                stepped[i*DIGIT_W +: DIGIT_W] = up_dn ? '0 : MAX_VEC[i*DIGIT_W +: DIGIT_W];
            end else if (up_dn) begin
                stepped[i*DIGIT_W +: DIGIT_W] = count_q[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
            end else begin
                stepped[i*DIGIT_W +: DIGIT_W] = count_q[i*DIGIT_W +: DIGIT_W] - DIGIT_W'(1);
            end
            if (load_val[i*DIGIT_W +: DIGIT_W] > MAX_VEC[i*DIGIT_W +: DIGIT_W]) begin
                clamped[i*DIGIT_W +: DIGIT_W] = MAX_VEC[i*DIGIT_W +: DIGIT_W];
            end else begin
                clamped[i*DIGIT_W +: DIGIT_W] = load_val[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = clamped;
            ovf_d   = 1'b0;
        end else if (en) begin
            count_d = stepped;
            if (tc_chain[NUM_DIGITS-1]) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef BCD_CHAIN_LAP_EN
    logic [W-1:0] lap_reg_q;

    // Captures the pre-update count, regardless of clr/load/en in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_reg_q <= '0;
        end else if (lap) begin
            lap_reg_q <= count_q;
        end
    end

    assign lap_q = lap_reg_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_q      = '0;
`endif

    assign Q        = count_q;
    assign ovf      = ovf_q;
    assign digit_tc = tc_chain;
    assign TC       = tc_chain[NUM_DIGITS-1];

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Self-checking bench for bcd_chain_counter (default parameters), using a mixed-radix integer model.
module tb_bcd_chain_counter;

    localparam int W = 24;
    localparam int ND = 6;
    localparam int TOTAL = 360000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic          up_dn = 1'b1;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic          lap = 1'b0;
    logic [W-1:0]  Q;
    logic [W-1:0]  lap_q;
    logic [ND-1:0] digit_tc;
    logic          TC;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    // Digit moduli, least significant first (mm:ss:cc).
    int mods [ND] = '{10, 10, 10, 6, 10, 6};

    int            m_val = 0;
    logic          m_ovf = 1'b0;
    logic [W-1:0]  m_lap = '0;
    logic [ND-1:0] e_dtc;
    logic          e_tc;
    logic [ND-1:0] s_dtc;
    logic          s_tc;

    bcd_chain_counter dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .up_dn(up_dn), .load(load),
        .load_val(load_val), .lap(lap), .Q(Q), .lap_q(lap_q), .digit_tc(digit_tc),
        .TC(TC), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic int to_int(logic [W-1:0] v);
        int acc = 0;
        int wt = 1;
        for (int i = 0; i < ND; i++) begin
            acc += int'(v[i*4 +: 4]) * wt;
            wt  *= mods[i];
        end
        return acc;
    endfunction

    function automatic logic [W-1:0] to_bcd(int n);
        logic [W-1:0] r = '0;
        int rem = n;
        for (int i = 0; i < ND; i++) begin
            r[i*4 +: 4] = 4'(rem % mods[i]);
            rem /= mods[i];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] clamp(logic [W-1:0] v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < ND; i++) begin
            if (int'(v[i*4 +: 4]) > mods[i] - 1) r[i*4 +: 4] = 4'(mods[i] - 1);
            else r[i*4 +: 4] = v[i*4 +: 4];
        end
        return r;
    endfunction

    // Digit i carries exactly when the low i+1 digits sit at their joint terminal value.
    function automatic logic [ND-1:0] model_dtc(int val, logic e, logic u);
        logic [ND-1:0] r = '0;
        int wt = 1;
        for (int i = 0; i < ND; i++) begin
            wt *= mods[i];
            r[i] = e && (u ? (val % wt == wt - 1) : (val % wt == 0));
        end
        return r;
    endfunction

    // One clock: drive at edge+1, sample combinational outputs mid-cycle, advance the model.
    task automatic cyc(input logic e, input logic c, input logic l, input logic [W-1:0] lv,
                       input logic u, input logic lp);
        en = e; clr = c; load = l; load_val = lv; up_dn = u; lap = lp;
        e_dtc = model_dtc(m_val, e, u);
        e_tc  = e_dtc[ND-1];
        #3;
        s_dtc = digit_tc;
        s_tc  = TC;
`ifdef BCD_CHAIN_LAP_EN
        if (lp) m_lap = to_bcd(m_val);
`endif
        if (c) begin
            m_val = 0; m_ovf = 1'b0;
        end else if (l) begin
            m_val = to_int(clamp(lv)); m_ovf = 1'b0;
        end else if (e) begin
            if (u) begin
                if (m_val == TOTAL - 1) begin m_val = 0; m_ovf = 1'b1; end
                else m_val = m_val + 1;
            end else begin
                if (m_val == 0) begin m_val = TOTAL - 1; m_ovf = 1'b1; end
                else m_val = m_val - 1;
            end
        end
        @(posedge clk);
        #1;
        en = 1'b0; clr = 1'b0; load = 1'b0; lap = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (Q !== '0 || lap_q !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_init got Q=%h lap=%h ovf=%b want 0", Q, lap_q, ovf);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b1, 24'h123456, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (Q !== 24'h123455) begin
            errors++;
            $display("FAIL reset_pre got %h want %h", Q, 24'h123455);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (Q !== '0 || lap_q !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got Q=%h lap=%h ovf=%b want 0", Q, lap_q, ovf);
        end
        m_val = 0; m_ovf = 1'b0; m_lap = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_carry;
        cyc(1'b0, 1'b0, 1'b1, 24'h000999, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (s_dtc !== 6'b000111 || s_tc !== 1'b0) begin
            errors++;
            $display("FAIL carry_tc got dtc=%b tc=%b want 000111 0", s_dtc, s_tc);
        end
        checks++;
        if (Q !== 24'h001000) begin
            errors++;
            $display("FAIL carry_q got %h want 001000", Q);
        end
    endtask

    task automatic test_wrap_up;
        cyc(1'b0, 1'b0, 1'b1, 24'h595999, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (s_tc !== 1'b1 || s_dtc !== 6'b111111) begin
            errors++;
            $display("FAIL wrap_up_tc got dtc=%b tc=%b want 111111 1", s_dtc, s_tc);
        end
        checks++;
        if (Q !== 24'h000000 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL wrap_up_q got Q=%h ovf=%b want 000000 1", Q, ovf);
        end
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (Q !== 24'h000005 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got Q=%h ovf=%b want 000005 1", Q, ovf);
        end
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (Q !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL clr got Q=%h ovf=%b want 000000 0", Q, ovf);
        end
    endtask

    task automatic test_wrap_down;
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (s_tc !== 1'b1) begin
            errors++;
            $display("FAIL wrap_dn_tc got %b want 1", s_tc);
        end
        checks++;
        if (Q !== 24'h595999 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL wrap_dn_q got Q=%h ovf=%b want 595999 1", Q, ovf);
        end
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (Q !== 24'h595998 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL dn_step got Q=%h ovf=%b want 595998 1", Q, ovf);
        end
    endtask

    task automatic test_load_clamp;
        cyc(1'b1, 1'b0, 1'b1, 24'h7F9A99, 1'b1, 1'b0);
        checks++;
        if (Q !== 24'h595999 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp got Q=%h ovf=%b want 595999 0", Q, ovf);
        end
        cyc(1'b1, 1'b1, 1'b1, 24'h123456, 1'b1, 1'b0);
        checks++;
        if (Q !== '0) begin
            errors++;
            $display("FAIL clr_over_load got %h want 000000", Q);
        end
    endtask

    task automatic test_lap;
        logic [W-1:0] want;
        cyc(1'b0, 1'b0, 1'b1, 24'h012345, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);
`ifdef BCD_CHAIN_LAP_EN
        want = 24'h012345;
`else
        want = 24'h000000;
`endif
        checks++;
        if (lap_q !== want || Q !== '0) begin
            errors++;
            $display("FAIL lap_clr got lap=%h Q=%h want %h 000000", lap_q, Q, want);
        end
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (lap_q !== want) begin
            errors++;
            $display("FAIL lap_hold got %h want %h", lap_q, want);
        end
    endtask

    task automatic test_back_to_back;
        cyc(1'b0, 1'b0, 1'b1, 24'h005990, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 1'b0, 1'b0, '0, k < 25, 1'b0);
            checks++;
            if (Q !== to_bcd(m_val) || s_dtc !== e_dtc) begin
                errors++;
                $display("FAIL b2b[%0d] got Q=%h dtc=%b want %h %b", k, Q, s_dtc,
                         to_bcd(m_val), e_dtc);
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] lv;
        logic         u = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 49) == 0) u = ~u;
            case ($urandom_range(0, 3))
                0: lv = $urandom();
                1: lv = 24'h595995;
                2: lv = 24'h000004;
                default: lv = to_bcd(int'($urandom_range(0, TOTAL - 1)));
            endcase
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 79) == 0,
                $urandom_range(0, 24) == 0, lv, u, $urandom_range(0, 7) == 0);
            checks++;
            if (s_dtc !== e_dtc || s_tc !== e_tc) begin
                errors++;
                $display("FAIL rand_tc[%0d] got %b/%b want %b/%b", k, s_dtc, s_tc, e_dtc, e_tc);
            end
            checks++;
            if (Q !== to_bcd(m_val) || ovf !== m_ovf || lap_q !== m_lap) begin
                errors++;
                $display("FAIL rand_q[%0d] got Q=%h ovf=%b lap=%h want %h %b %h", k, Q, ovf,
                         lap_q, to_bcd(m_val), m_ovf, m_lap);
            end
        end
    endtask

    initial begin
        test_reset;
        test_carry;
        test_wrap_up;
        test_wrap_down;
        test_load_clamp;
        test_lap;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
